// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-port request arbiter and sequencer for the shared 32-bit ALU (optional macro ALU_ARB_RR_EN selects round-robin)
module alu_req_arbiter #(
    parameter bit ERR_ON_BAD_OP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_id,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic [2:0]  lat_op;
    logic        lat_id;

    logic        grant0;
    logic        grant1;
    logic [31:0] alu_c;
    logic        bad_op;
    logic        big_shift;

    // Arbitration: a lone valid always wins; contention resolved by the build-time policy
    always_comb begin
`ifdef ALU_ARB_RR_EN
        grant1 = req1_valid && (!req0_valid || (last_grant == 1'b0));
`else
        grant1 = req1_valid && !req0_valid;
`endif
        grant0 = req0_valid && !grant1;
    end

    // Readies are only offered in IDLE, and never while reset is asserted
    assign req0_ready = !reset && (state == IDLE) && grant0;
    assign req1_ready = !reset && (state == IDLE) && grant1;

    // ALU on the latched operands; shift amounts of 32 or more saturate
    always_comb begin
        big_shift = |lat_b[31:5];
        bad_op    = (lat_op[2:1] == 2'b11);
        alu_c     = 32'd0;
        case (lat_op)
            3'b000: alu_c = lat_a + lat_b;
            3'b001: alu_c = lat_a - lat_b;
            3'b010: alu_c = lat_a & lat_b;
            3'b011: alu_c = lat_a | lat_b;
            3'b100: alu_c = big_shift ? 32'd0 : (lat_a >> lat_b[4:0]);
            3'b101: alu_c = big_shift ? {32{lat_a[31]}}
                                      : 32'($signed(lat_a) >>> lat_b[4:0]);
            default: alu_c = 32'd0;
        endcase
    end

    // Sequencer FSM: latch the winner, evaluate once, hold the response until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_a      <= 32'd0;
            lat_b      <= 32'd0;
            lat_op     <= 3'd0;
            lat_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_c      <= 32'd0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        lat_a      <= grant1 ? req1_a  : req0_a;
                        lat_b      <= grant1 ? req1_b  : req0_b;
                        lat_op     <= grant1 ? req1_op : req0_op;
                        lat_id     <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_c     <= alu_c;
                    rsp_id    <= lat_id;
                    rsp_err   <= ERR_ON_BAD_OP && bad_op;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.ERR_ON_BAD_OP(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_c;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic do_op(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.port == 0) begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end else begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end
        #1;
        chk({tag, "_ready"}, (v.port == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_rsp_valid"}, rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_c"}, rsp_c, v.exp_c);
        chk({tag, "_rsp_id"}, rsp_id, v.port);
        chk({tag, "_rsp_err"}, rsp_err, v.exp_err);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done_rsp_valid"}, rsp_valid, 0);
    endtask

    // Kill check after a reset pulse: nothing emitted, then IDLE grants contention to port 0
    task automatic check_killed(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_no_rsp"}, rsp_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 0; req1_b = 0; req1_op = 3'b000;
        #1;
        chk({tag, "_grant0_ready0"}, req0_ready, 1);
        chk({tag, "_grant0_ready1"}, req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        logic [0:0] exp_ids[8];
        logic [0:0] got_ids[8];
        int n0, n1, got;

        vecs[0]  = '{0, 32'h7FFF_FFFF, 32'd1,         3'b000, 32'h8000_0000, 1'b0};
        vecs[1]  = '{1, 32'h8000_0000, 32'd4,         3'b101, 32'hF800_0000, 1'b0};
        vecs[2]  = '{1, 32'h8000_0000, 32'd40,        3'b101, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1, 32'h8000_0000, 32'd40,        3'b100, 32'h0000_0000, 1'b0};
        vecs[4]  = '{0, 32'd5,         32'd7,         3'b001, 32'hFFFF_FFFE, 1'b0};
        vecs[5]  = '{0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'h00F0_00F0, 1'b0};
        vecs[6]  = '{1, 32'hF0F0_F0F0, 32'h0F00_0000, 3'b011, 32'hFFF0_F0F0, 1'b0};
        vecs[7]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1, 32'h1234_5678, 32'd1,         3'b111, 32'h0000_0000, 1'b1};
        vecs[9]  = '{0, 32'h8000_0000, 32'd31,        3'b100, 32'h0000_0001, 1'b0};
        vecs[10] = '{1, 32'h7FFF_FFFF, 32'd32,        3'b101, 32'h0000_0000, 1'b0};
        vecs[11] = '{0, 32'd0,         32'd1,         3'b001, 32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{1, 32'h8000_0001, 32'hFFFF_FFFF, 3'b101, 32'hFFFF_FFFF, 1'b0};

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 1'b1; req1_a = 0; req1_b = 0; req1_op = 0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready0_forced", req0_ready, 0);
        chk("reset_ready1_forced", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_c", rsp_c, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_err", rsp_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) do_op(i, vecs[i]);

        // Contention: both ports held valid for four ops each
        do_reset();
`ifdef ALU_ARB_RR_EN
        for (int i = 0; i < 8; i++) exp_ids[i] = 1'(i % 2);
`else
        for (int i = 0; i < 8; i++) exp_ids[i] = (i < 4) ? 1'b0 : 1'b1;
`endif
        req0_a = 32'd0; req0_b = 0; req0_op = 3'b011;
        req1_a = 32'd1; req1_b = 0; req1_op = 3'b011;
        rsp_ready = 1'b1;
        n0 = 4; n1 = 4; got = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            req0_valid = (n0 > 0);
            req1_valid = (n1 > 0);
            #1;
            if (rsp_valid) begin
                got_ids[got] = rsp_id;
                chk($sformatf("cont_rsp_c%0d", got), rsp_c, {31'd0, exp_ids[got]});
                got++;
            end
            if (req0_ready) n0--;
            if (req1_ready) n1--;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("cont_count", got, 8);
        for (int i = 0; i < got; i++)
            chk($sformatf("cont_id%0d", i), got_ids[i], exp_ids[i]);
        @(negedge clk);

        // Backpressure on a 5-7 subtract with port 1 waiting
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b001;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b000;
        #1;
        chk("bp_exec_ready1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_c", rsp_c, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold_c%0d", i), rsp_c, 32'hFFFF_FFFE);
            chk($sformatf("bp_hold_valid%0d", i), rsp_valid, 1);
            chk($sformatf("bp_hold_ready0_%0d", i), req0_ready, 0);
            chk($sformatf("bp_hold_ready1_%0d", i), req1_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_after_ready1", req1_ready, 1);
        chk("bp_after_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_p1_rsp_valid", rsp_valid, 1);
        chk("bp_p1_rsp_c", rsp_c, 32'd3);
        chk("bp_p1_rsp_id", rsp_id, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while in EXEC
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b000;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        do_reset();
        check_killed("rst_exec");

        // Reset while in RESP
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b000;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_pre_valid", rsp_valid, 1);
        do_reset();
        chk("rst_resp_rsp_c", rsp_c, 0);
        check_killed("rst_resp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
